// File: rtl/alu_operand_stage.sv
// ID/EX operand register feeding the ALU: forwarding, load-use stall detection, valid/ready toward EX.
// Optional feature: define ALU_OPERAND_FWD_EN to enable EX/WB result forwarding.
`ifndef ALU_ADD
`define ALU_ADD 4'h0
`endif
`ifndef ALU_XXX
`define ALU_XXX 4'hF
`endif

module alu_operand_stage #(
  parameter int DWIDTH = 32,
  parameter int OPW    = 4,
  parameter int RW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [RW-1:0]     id_rs_addr,
  input  logic [RW-1:0]     id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [DWIDTH-1:0] id_rs_data,
  input  logic [DWIDTH-1:0] id_rt_data,
  input  logic [DWIDTH-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [OPW-1:0]    id_ALUop,
  input  logic [RW-1:0]     id_rd_addr,
  input  logic              id_reg_we,
  input  logic              id_is_load,
  input  logic              fw_ex_we,
  input  logic [RW-1:0]     fw_ex_addr,
  input  logic [DWIDTH-1:0] fw_ex_data,
  input  logic              fw_ex_is_load,
  input  logic              fw_wb_we,
  input  logic [RW-1:0]     fw_wb_addr,
  input  logic [DWIDTH-1:0] fw_wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DWIDTH-1:0] A,
  output logic [DWIDTH-1:0] B,
  output logic [OPW-1:0]    ALUop,
  output logic [DWIDTH-1:0] ex_store_data,
  output logic [RW-1:0]     ex_rd_addr,
  output logic              ex_reg_we,
  output logic              ex_is_load,
  output logic              load_use_stall
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] a_q, a_d, b_q, b_d, store_q, store_d;
  logic [OPW-1:0]    op_q, op_d;
  logic [RW-1:0]     rd_q, rd_d;
  logic              we_q, we_d, ld_q, ld_d;

  logic              rs_hit_ex, rt_hit_ex, rs_hit_wb, rt_hit_wb;
  logic [DWIDTH-1:0] rs_val, rt_val;
  logic              fire;

  // A source only hazards when it is actually read and is not the zero register.
  always_comb begin
    rs_hit_ex = id_rs_used && (id_rs_addr != '0) && fw_ex_we && (fw_ex_addr == id_rs_addr);
    rt_hit_ex = id_rt_used && (id_rt_addr != '0) && fw_ex_we && (fw_ex_addr == id_rt_addr);
    rs_hit_wb = id_rs_used && (id_rs_addr != '0) && fw_wb_we && (fw_wb_addr == id_rs_addr);
    rt_hit_wb = id_rt_used && (id_rt_addr != '0) && fw_wb_we && (fw_wb_addr == id_rt_addr);
  end

`ifdef ALU_OPERAND_FWD_EN
  // EX/MEM is younger than WB, so it wins; a load in EX has no data yet and stalls instead.
  always_comb begin
    load_use_stall = fw_ex_is_load && (rs_hit_ex || rt_hit_ex);
    rs_val = (rs_hit_ex && !fw_ex_is_load) ? fw_ex_data :
             rs_hit_wb                     ? fw_wb_data : id_rs_data;
    rt_val = (rt_hit_ex && !fw_ex_is_load) ? fw_ex_data :
             rt_hit_wb                     ? fw_wb_data : id_rt_data;
  end
`else
  // Without bypass paths, wait until every in-flight producer of a used source retires.
  logic unused_fw;
  assign unused_fw = ^{fw_ex_data, fw_wb_data, fw_ex_is_load};

  always_comb begin
    load_use_stall = rs_hit_ex || rt_hit_ex || rs_hit_wb || rt_hit_wb;
    rs_val         = id_rs_data;
    rt_val         = id_rt_data;
  end
`endif

  assign id_ready = ((state_q == EMPTY) || ex_ready) && !load_use_stall && !flush;
  assign fire     = id_valid && id_ready;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    store_d = store_q;
    op_d    = op_q;
    rd_d    = rd_q;
    we_d    = we_q;
    ld_d    = ld_q;
    if (flush) begin
      state_d = EMPTY;
      we_d    = 1'b0;
      ld_d    = 1'b0;
    end else if (fire) begin
      state_d = FULL;
      a_d     = rs_val;
      b_d     = id_use_imm ? id_imm : rt_val;
      store_d = rt_val;
      op_d    = id_ALUop;
      rd_d    = id_rd_addr;
      we_d    = id_reg_we;
      ld_d    = id_is_load;
    end else if ((state_q == FULL) && ex_ready) begin
      // Drained with nothing behind it: leave a bubble that cannot write back.
      state_d = EMPTY;
      we_d    = 1'b0;
      ld_d    = 1'b0;
    end
  end

  // NOTE: the operand registers are reset too, so the ALU sees defined inputs right after reset.
  // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      store_q <= '0;
      op_q    <= OPW'(`ALU_XXX);
      rd_q    <= '0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      store_q <= store_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      ld_q    <= ld_d;
    end
  end

  assign ex_valid      = (state_q == FULL);
  assign A             = a_q;
  assign B             = b_q;
  assign ALUop         = op_q;
  assign ex_store_data = store_q;
  assign ex_rd_addr    = rd_q;
  assign ex_reg_we     = we_q;
  assign ex_is_load    = ld_q;

endmodule
